// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 control path: opcodes, state encoding,
// PC mux and ALU encodings, and the control word produced by the decoder.
// Optional feature macro: LC3_CTRL_TRAP_EN adds the TRAP (1111) sequence.
package lc3_pkg;

   localparam logic [3:0] OP_BR   = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_LD   = 4'b0010;
   localparam logic [3:0] OP_ST   = 4'b0011;
   localparam logic [3:0] OP_AND  = 4'b0101;
   localparam logic [3:0] OP_NOT  = 4'b1001;
   localparam logic [3:0] OP_JMP  = 4'b1100;
   localparam logic [3:0] OP_LEA  = 4'b1110;
   localparam logic [3:0] OP_TRAP = 4'b1111;

   localparam logic [1:0] PCMUX_INC  = 2'b00;
   localparam logic [1:0] PCMUX_BUS  = 2'b01;
   localparam logic [1:0] PCMUX_ADDR = 2'b10;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_AND   = 2'b01;
   localparam logic [1:0] ALU_NOT   = 2'b10;
   localparam logic [1:0] ALU_PASSA = 2'b11;

   typedef enum logic [4:0] {
      S_IDLE   = 5'd0,
      S_F0     = 5'd1,
      S_F1     = 5'd2,
      S_F2     = 5'd3,
      S_DEC    = 5'd4,
      S_EX_ADD = 5'd5,
      S_EX_AND = 5'd6,
      S_EX_NOT = 5'd7,
      S_BR_T   = 5'd8,
      S_JMP    = 5'd9,
      S_LEA    = 5'd10,
      S_LD_MA  = 5'd11,
      S_LD_RD  = 5'd12,
      S_LD_WB  = 5'd13,
      S_ST_MA  = 5'd14,
      S_ST_SD  = 5'd15,
`ifdef LC3_CTRL_TRAP_EN
      S_ST_WR  = 5'd16,
      S_T0     = 5'd17,
      S_T1     = 5'd18,
      S_T2     = 5'd19,
      S_T3     = 5'd20
`else
      S_ST_WR  = 5'd16
`endif
   } state_t;

   // Moore control word; ld_mdr here covers only the state-decoded load.
   typedef struct packed {
      logic       ld_pc;
      logic [1:0] pc_mux;
      logic       addr_sel;
      logic       marmux_sel;
      logic       ld_mar;
      logic       ld_mdr;
      logic       ld_ir;
      logic       ld_reg;
      logic       ld_cc;
      logic       gate_pc;
      logic       gate_mdr;
      logic       gate_alu;
      logic       gate_marmux;
      logic [1:0] alu_op;
      logic       dr_r7;
      logic       mem_en;
      logic       mem_we;
      logic       illegal;
   } ctrl_t;

   // True for opcodes this sequencer knows how to execute.
   function automatic logic is_legal(input logic [3:0] op);
      case (op)
         OP_BR, OP_ADD, OP_LD, OP_ST, OP_AND, OP_NOT, OP_JMP, OP_LEA: is_legal = 1'b1;
`ifdef LC3_CTRL_TRAP_EN
         OP_TRAP: is_legal = 1'b1;
`endif
         default: is_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lc3_ctrl_decode.sv
// State-to-control-word decoder for the LC-3 microsequencer. Purely
// combinational; the opcode is only consulted in DEC to flag illegal ones.
// Optional feature macro: LC3_CTRL_TRAP_EN decodes the T0..T3 states.
module lc3_ctrl_decode
   import lc3_pkg::*;
(
   input  state_t     state,
   input  logic [3:0] opcode,
   output ctrl_t      ctrl
);

   // Every state starts from an all-zero word so IDLE drives nothing.
   always_comb begin
      ctrl = '0;
      case (state)
         S_F0: begin
            ctrl.gate_pc = 1'b1;
            ctrl.ld_mar  = 1'b1;
            ctrl.ld_pc   = 1'b1;
            ctrl.pc_mux  = PCMUX_INC;
         end
         S_F1:     ctrl.mem_en = 1'b1;
         S_F2: begin
            ctrl.gate_mdr = 1'b1;
            ctrl.ld_ir    = 1'b1;
         end
         S_DEC:    ctrl.illegal = ~is_legal(opcode);
         S_EX_ADD: begin
            ctrl.gate_alu = 1'b1;
            ctrl.alu_op   = ALU_ADD;
            ctrl.ld_reg   = 1'b1;
            ctrl.ld_cc    = 1'b1;
         end
         S_EX_AND: begin
            ctrl.gate_alu = 1'b1;
            ctrl.alu_op   = ALU_AND;
            ctrl.ld_reg   = 1'b1;
            ctrl.ld_cc    = 1'b1;
         end
         S_EX_NOT: begin
            ctrl.gate_alu = 1'b1;
            ctrl.alu_op   = ALU_NOT;
            ctrl.ld_reg   = 1'b1;
            ctrl.ld_cc    = 1'b1;
         end
         S_BR_T: begin
            ctrl.ld_pc    = 1'b1;
            ctrl.pc_mux   = PCMUX_ADDR;
            ctrl.addr_sel = 1'b0;
         end
         S_JMP: begin
            ctrl.ld_pc    = 1'b1;
            ctrl.pc_mux   = PCMUX_ADDR;
            ctrl.addr_sel = 1'b1;
         end
         S_LEA: begin
            ctrl.gate_marmux = 1'b1;
            ctrl.addr_sel    = 1'b0;
            ctrl.ld_reg      = 1'b1;
         end
         S_LD_MA, S_ST_MA: begin
            ctrl.gate_marmux = 1'b1;
            ctrl.ld_mar      = 1'b1;
         end
         S_LD_RD:  ctrl.mem_en = 1'b1;
         S_LD_WB: begin
            ctrl.gate_mdr = 1'b1;
            ctrl.ld_reg   = 1'b1;
            ctrl.ld_cc    = 1'b1;
         end
         S_ST_SD: begin
            ctrl.gate_alu = 1'b1;
            ctrl.alu_op   = ALU_PASSA;
            ctrl.ld_mdr   = 1'b1;
         end
         S_ST_WR: begin
            ctrl.mem_en = 1'b1;
            ctrl.mem_we = 1'b1;
         end
`ifdef LC3_CTRL_TRAP_EN
         S_T0: begin
            ctrl.gate_pc = 1'b1;
            ctrl.ld_reg  = 1'b1;
            ctrl.dr_r7   = 1'b1;
         end
         S_T1: begin
            ctrl.gate_marmux = 1'b1;
            ctrl.marmux_sel  = 1'b1;
            ctrl.ld_mar      = 1'b1;
         end
         S_T2:     ctrl.mem_en = 1'b1;
         S_T3: begin
            ctrl.gate_mdr = 1'b1;
            ctrl.ld_pc    = 1'b1;
            ctrl.pc_mux   = PCMUX_BUS;
         end
`endif
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/lc3_ctrl_fsm.sv
// LC-3 microsequencer: fetch / decode / execute state machine driving the
// PC, MAR/MDR/IR, register file and condition-code controls.
// Optional feature macro: LC3_CTRL_TRAP_EN enables TRAP execution.
//
// Memory handshake: mem_en (and mem_we for writes) is decoded from state,
// so it rises on entry to a memory state and stays constant until the cycle
// in which mem_ready=1; the access completes on that rising edge and the
// sequencer leaves the memory state. A read's data is captured into MDR in
// that same cycle (ld_mdr = mem_en & ~mem_we & mem_ready).
module lc3_ctrl_fsm
   import lc3_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   input  logic [15:0] ir,
   input  logic        n,
   input  logic        z,
   input  logic        p,
   input  logic        mem_ready,
   output logic        ld_pc,
   output logic [1:0]  pc_mux,
   output logic        addr_sel,
   output logic        marmux_sel,
   output logic        ld_mar,
   output logic        ld_mdr,
   output logic        ld_ir,
   output logic        ld_reg,
   output logic        ld_cc,
   output logic        gate_pc,
   output logic        gate_mdr,
   output logic        gate_alu,
   output logic        gate_marmux,
   output logic [1:0]  alu_op,
   output logic        dr_r7,
   output logic        mem_en,
   output logic        mem_we,
   output logic        illegal,
   output logic [4:0]  state
);

   state_t     state_q;
   state_t     state_d;
   state_t     end_state;
   ctrl_t      ctrl;
   logic [3:0] opcode;
   logic       ben;
   logic       unused_ir;

   assign opcode    = ir[15:12];
   assign ben       = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);
   assign end_state = run ? S_F0 : S_IDLE;
   // Offset fields are consumed by the datapath, not the sequencer.
   assign unused_ir = ^ir[8:0];

   // Next-state selection; run is sampled only at instruction boundaries.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (run) state_d = S_F0;
         S_F0:   state_d = S_F1;
         S_F1:   if (mem_ready) state_d = S_F2;
         S_F2:   state_d = S_DEC;
         S_DEC: begin
            case (opcode)
               OP_ADD:  state_d = S_EX_ADD;
               OP_AND:  state_d = S_EX_AND;
               OP_NOT:  state_d = S_EX_NOT;
               OP_BR:   state_d = ben ? S_BR_T : end_state;
               OP_JMP:  state_d = S_JMP;
               OP_LEA:  state_d = S_LEA;
               OP_LD:   state_d = S_LD_MA;
               OP_ST:   state_d = S_ST_MA;
`ifdef LC3_CTRL_TRAP_EN
               OP_TRAP: state_d = S_T0;
`endif
               default: state_d = end_state;
            endcase
         end
         S_EX_ADD, S_EX_AND, S_EX_NOT, S_BR_T, S_JMP, S_LEA, S_LD_WB:
            state_d = end_state;
         S_LD_MA: state_d = S_LD_RD;
         S_LD_RD: if (mem_ready) state_d = S_LD_WB;
         S_ST_MA: state_d = S_ST_SD;
         S_ST_SD: state_d = S_ST_WR;
         S_ST_WR: if (mem_ready) state_d = end_state;
`ifdef LC3_CTRL_TRAP_EN
         S_T0:    state_d = S_T1;
         S_T1:    state_d = S_T2;
         S_T2:    if (mem_ready) state_d = S_T3;
         S_T3:    state_d = end_state;
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // State register; reset lands in IDLE, whose control word is all zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   lc3_ctrl_decode u_decode (
      .state  (state_q),
      .opcode (opcode),
      .ctrl   (ctrl)
   );

   assign ld_pc       = ctrl.ld_pc;
   assign pc_mux      = ctrl.pc_mux;
   assign addr_sel    = ctrl.addr_sel;
   assign marmux_sel  = ctrl.marmux_sel;
   assign ld_mar      = ctrl.ld_mar;
   assign ld_mdr      = ctrl.ld_mdr | (ctrl.mem_en & ~ctrl.mem_we & mem_ready);
   assign ld_ir       = ctrl.ld_ir;
   assign ld_reg      = ctrl.ld_reg;
   assign ld_cc       = ctrl.ld_cc;
   assign gate_pc     = ctrl.gate_pc;
   assign gate_mdr    = ctrl.gate_mdr;
   assign gate_alu    = ctrl.gate_alu;
   assign gate_marmux = ctrl.gate_marmux;
   assign alu_op      = ctrl.alu_op;
   assign dr_r7       = ctrl.dr_r7;
   assign mem_en      = ctrl.mem_en;
   assign mem_we      = ctrl.mem_we;
   assign illegal     = ctrl.illegal;
   assign state       = state_q;

endmodule

// File: tb/tb_lc3_ctrl_fsm.sv
// Self-checking bench for lc3_ctrl_fsm: directed test-plan cases followed
// by random instructions with random memory wait states, each instruction
// checked against a per-instruction model of length and strobe counts.
module tb_lc3_ctrl_fsm;
   import lc3_pkg::*;

`ifdef LC3_CTRL_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        run;
   logic [15:0] ir;
   logic        n, z, p;
   logic        mem_ready;
   logic        ld_pc;
   logic [1:0]  pc_mux;
   logic        addr_sel, marmux_sel, ld_mar, ld_mdr, ld_ir, ld_reg, ld_cc;
   logic        gate_pc, gate_mdr, gate_alu, gate_marmux;
   logic [1:0]  alu_op;
   logic        dr_r7, mem_en, mem_we, illegal;
   logic [4:0]  state;

   int checks;
   int errors;
   int wait_left;
   int cur_wd;

   // Output vector of a fetch-start cycle: MAR<-PC, PC<-PC+1, nothing else.
   localparam logic [19:0] F0_VEC = {1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                     1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};

   lc3_ctrl_fsm dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .run         (run),
      .ir          (ir),
      .n           (n),
      .z           (z),
      .p           (p),
      .mem_ready   (mem_ready),
      .ld_pc       (ld_pc),
      .pc_mux      (pc_mux),
      .addr_sel    (addr_sel),
      .marmux_sel  (marmux_sel),
      .ld_mar      (ld_mar),
      .ld_mdr      (ld_mdr),
      .ld_ir       (ld_ir),
      .ld_reg      (ld_reg),
      .ld_cc       (ld_cc),
      .gate_pc     (gate_pc),
      .gate_mdr    (gate_mdr),
      .gate_alu    (gate_alu),
      .gate_marmux (gate_marmux),
      .alu_op      (alu_op),
      .dr_r7       (dr_r7),
      .mem_en      (mem_en),
      .mem_we      (mem_we),
      .illegal     (illegal),
      .state       (state)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [19:0] outs();
      return {ld_pc, pc_mux, addr_sel, marmux_sel, ld_mar, ld_mdr, ld_ir, ld_reg, ld_cc,
              gate_pc, gate_mdr, gate_alu, gate_marmux, alu_op, dr_r7, mem_en, mem_we, illegal};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Memory responder: each access waits the programmed number of cycles.
   task automatic drive_mem();
      if (mem_en) begin
         if (wait_left == 0) mem_ready = 1'b1;
         else begin
            mem_ready = 1'b0;
            wait_left--;
         end
      end else begin
         mem_ready = 1'($urandom_range(0, 1));
      end
   endtask

   // Runs one instruction starting in its fetch cycle and compares length
   // and strobe totals with what the instruction rules predict.
   task automatic run_instr(input string nm, input logic [15:0] i_ir, input logic [2:0] nzp,
                            input int wf, input int wd, input logic run_after);
      logic [3:0] op;
      bit is_alu, is_br, taken, is_jmp, is_lea, is_ld, is_st, is_trap, is_ill, done;
      int len, e_len, e_alu;
      int c_ld_pc, c_ld_ir, c_ld_reg, c_ld_cc, c_ld_mdr, c_mem_en, c_mem_we;
      int c_ill, c_r7, c_marmux, c_clash, alu_seen;
      logic [1:0] pc2;
      logic       as2;

      ir = i_ir; {n, z, p} = nzp; run = run_after;
      wait_left = wf; cur_wd = wd;
      op      = i_ir[15:12];
      is_alu  = (op == 4'b0001) || (op == 4'b0101) || (op == 4'b1001);
      is_br   = (op == 4'b0000);
      taken   = is_br && ((i_ir[11] & nzp[2]) | (i_ir[10] & nzp[1]) | (i_ir[9] & nzp[0]));
      is_jmp  = (op == 4'b1100);
      is_lea  = (op == 4'b1110);
      is_ld   = (op == 4'b0010);
      is_st   = (op == 4'b0011);
      is_trap = (op == 4'b1111) && TRAP_EN;
      is_ill  = !(is_alu || is_br || is_jmp || is_lea || is_ld || is_st || is_trap);

      e_len = 4 + wf;
      if (is_alu || is_jmp || is_lea || taken) e_len += 1;
      if (is_ld || is_st) e_len += 3 + wd;
      if (is_trap) e_len += 4 + wd;
      e_alu = -1;
      if (op == 4'b0001) e_alu = 0;
      if (op == 4'b0101) e_alu = 1;
      if (op == 4'b1001) e_alu = 2;
      if (is_st) e_alu = 3;

      c_ld_pc = 0; c_ld_ir = 0; c_ld_reg = 0; c_ld_cc = 0; c_ld_mdr = 0; c_mem_en = 0;
      c_mem_we = 0; c_ill = 0; c_r7 = 0; c_marmux = 0; c_clash = 0; alu_seen = -1;
      pc2 = 2'b11; as2 = 1'b0;

      drive_mem();
      #1;
      check({nm, "_f0"}, 32'(outs()), 32'(F0_VEC));
      len = 1; done = 0;
      while (!done) begin
         // accumulate the cycle just sampled
         if (ld_pc) begin
            c_ld_pc++;
            if (len > 1) begin pc2 = pc_mux; as2 = addr_sel; end
         end
         c_ld_ir  += int'(ld_ir);
         c_ld_reg += int'(ld_reg);
         c_ld_cc  += int'(ld_cc);
         c_ld_mdr += int'(ld_mdr);
         c_mem_en += int'(mem_en);
         c_mem_we += int'(mem_we);
         c_ill    += int'(illegal);
         c_r7     += int'(dr_r7 & gate_pc & ld_reg);
         c_marmux += int'(gate_marmux);
         if (int'(gate_pc) + int'(gate_mdr) + int'(gate_alu) + int'(gate_marmux) > 1) c_clash++;
         if (gate_alu) alu_seen = int'(alu_op);
         if (mem_en && mem_ready) wait_left = cur_wd;
         @(negedge clk);
         drive_mem();
         #1;
         if (run_after ? (outs() === F0_VEC) : (state === 5'(S_IDLE))) done = 1;
         else begin
            len++;
            if (len > 64) begin
               check({nm, "_timeout"}, 32'(len), 32'(e_len));
               done = 1;
            end
         end
      end

      check({nm, "_len"},    32'(len),      32'(e_len));
      check({nm, "_ld_pc"},  32'(c_ld_pc),  32'(1 + int'(taken || is_jmp || is_trap)));
      check({nm, "_ld_ir"},  32'(c_ld_ir),  32'd1);
      check({nm, "_ld_reg"}, 32'(c_ld_reg), 32'(int'(is_alu || is_lea || is_ld || is_trap)));
      check({nm, "_ld_cc"},  32'(c_ld_cc),  32'(int'(is_alu || is_ld)));
      check({nm, "_ld_mdr"}, 32'(c_ld_mdr), 32'(1 + int'(is_ld) + int'(is_st) + int'(is_trap)));
      check({nm, "_mem_en"}, 32'(c_mem_en), 32'(1 + wf + ((is_ld || is_st || is_trap) ? 1 + wd : 0)));
      check({nm, "_mem_we"}, 32'(c_mem_we), 32'(is_st ? 1 + wd : 0));
      check({nm, "_illegal"}, 32'(c_ill),   32'(int'(is_ill)));
      check({nm, "_r7"},     32'(c_r7),     32'(int'(is_trap)));
      check({nm, "_marmux"}, 32'(c_marmux), 32'(int'(is_lea || is_ld || is_st || is_trap)));
      check({nm, "_clash"},  32'(c_clash),  32'd0);
      check({nm, "_alu_op"}, 32'(alu_seen), 32'(e_alu));
      if (taken || is_jmp) begin
         check({nm, "_pcmux"},  32'(pc2), 32'(2'b10));
         check({nm, "_addrsel"}, 32'(as2), 32'(is_jmp));
      end
      if (is_trap) check({nm, "_pcmux"}, 32'(pc2), 32'(2'b01));
   endtask

   initial begin
      logic [3:0] ops [11];
      logic [15:0] r_ir;
      checks = 0; errors = 0; wait_left = 0; cur_wd = 0;
      ops = '{4'b0001, 4'b0101, 4'b1001, 4'b0000, 4'b1100, 4'b1110,
              4'b0010, 4'b0011, 4'b1111, 4'b0100, 4'b1101};

      // Reset and idle
      rst_n = 1'b0; run = 1'b0; ir = '0; {n, z, p} = 3'b000; mem_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_outs",  32'(outs()), 32'd0);
      check("reset_state", 32'(state),  32'(5'(S_IDLE)));
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("idle_hold", 32'(state), 32'(5'(S_IDLE)));

      // Reset in the middle of a fetch memory wait
      run = 1'b1;
      @(negedge clk); #1;
      check("start_f0", 32'(outs()), 32'(F0_VEC));
      mem_ready = 1'b0;
      @(negedge clk); #1;
      check("f1_mem_en", 32'(mem_en), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_mem_en", 32'(mem_en), 32'd0);
      check("mid_rst_outs",   32'(outs()), 32'd0);
      check("mid_rst_state",  32'(state),  32'(5'(S_IDLE)));
      @(negedge clk);
      rst_n = 1'b1; run = 1'b1;
      @(negedge clk); #1;
      check("post_rst_f0", 32'(outs()), 32'(F0_VEC));

      // Directed instructions
      run_instr("add",     16'h1042, 3'b000, 0, 0, 1'b1);
      run_instr("brz_t",   16'h0402, 3'b010, 0, 0, 1'b1);
      run_instr("brz_nt",  16'h0402, 3'b101, 0, 0, 1'b1);
      run_instr("ld_w3",   16'h2005, 3'b000, 0, 3, 1'b1);
      run_instr("st_w2",   16'h3005, 3'b000, 1, 2, 1'b1);
      run_instr("trap",    16'hF025, 3'b000, 0, 0, 1'b1);
      run_instr("jmp",     16'hC080, 3'b000, 0, 0, 1'b1);
      run_instr("lea",     16'hE005, 3'b001, 0, 0, 1'b1);
      run_instr("and",     16'h5042, 3'b000, 2, 0, 1'b1);
      run_instr("not",     16'h907F, 3'b000, 0, 0, 1'b1);
      run_instr("ill",     16'hD000, 3'b000, 0, 0, 1'b1);

      // Random instructions and wait states
      for (int i = 0; i < 40; i++) begin
         r_ir = {ops[$urandom_range(0, 10)], 12'($urandom())};
         run_instr("rnd", r_ir, 3'($urandom_range(0, 7)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1);
      end

      // Last instruction with run low returns to IDLE
      run_instr("last", 16'h1042, 3'b000, 0, 0, 1'b0);
      check("end_idle_outs", 32'(outs()), 32'd0);
      repeat (2) @(negedge clk);
      #1;
      check("end_idle_state", 32'(state), 32'(5'(S_IDLE)));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
